alu_mul_seq: RTL and testbench

- Multi-cycle unsigned shift-add multiplier sequencer that sits directly upstream of the 16-bit ALU.
- It drives the ALU's aluop/a/b inputs and consumes its result/ovf outputs.
- No dedicated multiplier array: the existing ripple ALU performs every partial-product add, one add per cycle.
- Produces the low 16 bits of a*b plus a sticky signed-overflow flag, with a start/busy/done handshake toward the control unit.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_mul_seq.sv | 92 +++++++++
 tb/tb_alu_mul_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluop encodings [inva invb ci op1 op0], datapath width
// and the multiplier sequencer state type.
package alu_pkg;
    localparam int ALU_WIDTH = 16;

    localparam logic [4:0] ALUOP_AND = 5'b00000;
    localparam logic [4:0] ALUOP_OR  = 5'b00001;
    localparam logic [4:0] ALUOP_ADD = 5'b00010;
    localparam logic [4:0] ALUOP_SUB = 5'b01110;
    localparam logic [4:0] ALUOP_SLT = 5'b01111;
    localparam logic [4:0] ALUOP_NOR = 5'b11000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer driving the shared ripple ALU, one add per cycle.
// Optional MUL_EARLY_EXIT_EN: leave RUN as soon as no multiplier bits remain.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [4:0]       alu_aluop,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    mul_state_t       state, state_n;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_add, prod_r;
    logic [CW-1:0]    cnt;
    logic             ovf_r, last;

    assign alu_aluop = ALUOP_ADD;
    assign alu_a     = acc;
    assign alu_b     = mcand;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign product   = prod_r;
    assign ovf       = ovf_r;

    // ALU sum is only committed when the current multiplier bit is set
    assign acc_add = mplier[0] ? alu_result : acc;

`ifdef MUL_EARLY_EXIT_EN
    assign last = (cnt == CW'(ITER - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last = (cnt == CW'(ITER - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            prod_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc    <= '0;
                    mcand  <= opa;
                    mplier <= opb;
                    cnt    <= '0;
                    ovf_r  <= 1'b0;
                end
                RUN: begin
                    acc    <= acc_add;
                    if (mplier[0]) ovf_r <= ovf_r | alu_ovf;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) prod_r <= acc_add;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to a behavioural 16-bit ALU; scoreboard of expected
// product/ovf pushed at start, popped on done. Honours MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] opa, opb;
    logic [4:0]  alu_aluop;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_ovf;
    logic        busy, done, ovf;
    logic [15:0] product;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          dcyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb),
        .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_ovf(alu_ovf),
        .busy(busy), .done(done), .product(product), .ovf(ovf)
    );

    // behavioural ALU: [inva invb ci op1 op0]
    logic [15:0] aa, bb, sum;
    always_comb begin
        aa  = alu_aluop[4] ? ~alu_a : alu_a;
        bb  = alu_aluop[3] ? ~alu_b : alu_b;
        sum = aa + bb + {15'd0, alu_aluop[2]};
        case (alu_aluop[1:0])
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            2'b10:   alu_result = sum;
            default: alu_result = {15'd0, sum[15] ^ ((aa[15] == bb[15]) && (sum[15] != aa[15]))};
        endcase
        alu_ovf = (aa[15] == bb[15]) && (sum[15] != aa[15]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] full;
        logic [15:0] acc, m, s;
        int          msb;
        full  = a * b;
        e.prod = full[15:0];
        e.ovf  = 1'b0;
        acc = '0;
        msb = 0;
        for (int i = 0; i < 16; i++) begin
            m = a << i;
            if (b[i]) begin
                s = acc + m;
                if ((acc[15] == m[15]) && (s[15] != acc[15])) e.ovf = 1'b1;
                acc = s;
                msb = i;
            end
        end
`ifdef MUL_EARLY_EXIT_EN
        e.dcyc = msb + 2;
`else
        e.dcyc = 17;
`endif
        return e;
    endfunction

    // start is sampled at the edge ending cycle 0; rst_at>0 asserts rst in that cycle
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit inj, input int rst_at);
        exp_t e, got;
        int   ndone, nk;
        e = model(a, b);
        sbq.push_back(e);
        ndone = 0;
        nk = inj ? 17 : 24;
        @(negedge clk);
        opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= nk; k++) begin
            if (rst_at > 0 && k == rst_at + 1) begin
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_prod", {16'd0, product}, 32'd0);
                chk("rst_ovf", {31'd0, ovf}, 32'd0);
                if (sbq.size() > 0) void'(sbq.pop_front());
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("done_cyc", k, e.dcyc);
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_empty got done want none");
                    end else begin
                        got = sbq.pop_front();
                        chk("product", {16'd0, product}, {16'd0, got.prod});
                        chk("ovf", {31'd0, ovf}, {31'd0, got.ovf});
                    end
                end
            end
            if (rst_at == 0)
                chk("busy", {31'd0, busy}, {31'd0, (k < e.dcyc)});
            else if (k <= rst_at)
                chk("busy_pre_rst", {31'd0, busy}, 32'd1);
            rst   = (k == rst_at);
            start = inj && (k == 5 || k == 17);
            if (start) begin opa = 16'hBEEF; opb = 16'hFFFF; end
            @(posedge clk); #1;
            rst = 1'b0;
            start = 1'b0;
        end
        chk("ndone", ndone, (rst_at > 0) ? 0 : 1);
        if (inj) begin
            chk("held_prod", {16'd0, product}, {16'd0, e.prod});
            chk("held_ovf", {31'd0, ovf}, {31'd0, e.ovf});
            chk("held_busy", {31'd0, busy}, 32'd0);
            chk("held_done", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_prod", {16'd0, product}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("aluop", {27'd0, alu_aluop}, 32'h2);
        rst = 1'b0;

        run_op(16'd3, 16'd5, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(16'h3000, 16'd3, 1'b0, 0);
        run_op(16'h1234, 16'h8765, 1'b1, 0);
        run_op(16'd7, 16'd1, 1'b0, 0);
        run_op(16'h00FF, 16'hFFFF, 1'b0, 8);
        run_op(16'hABCD, 16'h0000, 1'b0, 0);
        run_op(16'h0000, 16'h8001, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'b0, 0);
        chk("sb_left", sbq.size(), 0);
        chk("aluop_end", {27'd0, alu_aluop}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
